uart_cmd_handler: RTL and testbench

UART_CMD_HANDLER -- requirements
Module: uart_cmd_handler

---
 rtl/uart_cmd_handler_pkg.sv | 32 +++
 rtl/uart_cmd_handler_hamming.sv | 23 ++
 rtl/uart_cmd_handler.sv | 178 +++++++++++++++++
 tb/tb_uart_cmd_handler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_handler_pkg.sv
// Shared definitions for the UART command handler: FSM state encoding,
// command codes and the default ACK/NACK reply bytes.
package uart_cmd_handler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXEC      = 3'd2,
        ST_SEND_REQ  = 3'd3,
        ST_SEND_WAIT = 3'd4
    } state_e;

    localparam logic [3:0] CMD_ON     = 4'h1;
    localparam logic [3:0] CMD_OFF    = 4'h2;
    localparam logic [3:0] CMD_TOGGLE = 4'h3;
    localparam logic [3:0] CMD_SHOOT  = 4'h4;

    localparam logic [7:0] ACK_BYTE_DEF  = 8'h3C;
    localparam logic [7:0] NACK_BYTE_DEF = 8'hC3;

    // True for the four codes the handler knows how to execute.
    function automatic logic cmd_mapped(input logic [3:0] code);
        logic hit;
        hit = 1'b0;
        case (code)
            CMD_ON, CMD_OFF, CMD_TOGGLE, CMD_SHOOT: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/uart_cmd_handler_hamming.sv
// Hamming(7,4) single-error-correcting decoder. Bit i of hamming_in is
// code position i+1; data is taken from positions {7,6,5,3}.
module hamming_7_4_decoder (
    input  logic [6:0] hamming_in,
    output logic [3:0] data_out,
    output logic       error_detected
);

    logic [2:0] syndrome;

    // Syndrome is the position of the flipped bit; only data positions need fixing.
    always_comb begin
        syndrome[0] = hamming_in[0] ^ hamming_in[2] ^ hamming_in[4] ^ hamming_in[6];
        syndrome[1] = hamming_in[1] ^ hamming_in[2] ^ hamming_in[5] ^ hamming_in[6];
        syndrome[2] = hamming_in[3] ^ hamming_in[4] ^ hamming_in[5] ^ hamming_in[6];
        data_out[0] = hamming_in[2] ^ (syndrome == 3'd3);
        data_out[1] = hamming_in[4] ^ (syndrome == 3'd5);
        data_out[2] = hamming_in[5] ^ (syndrome == 3'd6);
        data_out[3] = hamming_in[6] ^ (syndrome == 3'd7);
        error_detected = (syndrome != 3'd0);
    end

endmodule

// File: rtl/uart_cmd_handler.sv
// UART command handler: decodes one received byte into an SPWM command,
// applies it, and answers with an ACK/NACK byte through uart_tx.
// Define UART_CMD_HAMMING_EN to decode the byte as Hamming(7,4) and count
// corrected single-bit errors in err_count.
//
// state        | meaning
// ST_IDLE      | waiting for rx_done (a captured byte moves on next cycle)
// ST_DECODE    | derive code and accept/reject from the captured byte
// ST_EXEC      | apply command, load ACK/NACK into data_to_tx
// ST_SEND_REQ  | start_tx high until tx_busy is seen
// ST_SEND_WAIT | wait for tx_busy low, then back to IDLE
module uart_cmd_handler
    import uart_cmd_handler_pkg::*;
#(
    parameter logic [7:0]  ACK_BYTE     = ACK_BYTE_DEF,
    parameter logic [7:0]  NACK_BYTE    = NACK_BYTE_DEF,
    parameter int unsigned PULSE_CYCLES = 48
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_received,
    input  logic       rx_done,
    input  logic       parity_error,
    input  logic       tx_busy,
    output logic [7:0] data_to_tx,
    output logic       start_tx,
    output logic       enable,
    output logic       shoot,
    output logic       busy,
    output logic [7:0] err_count,
    output logic       overrun
);

    localparam int unsigned CNT_W = $clog2(PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES);

    state_e           state_q, state_d;
    logic             pend_q;
    logic [7:0]       rx_byte_q;
    logic             perr_q;
    logic [3:0]       code_q;
    logic             accept_q;
    logic             enable_q;
    logic [7:0]       data_to_tx_q;
    logic             overrun_q;
    logic [CNT_W-1:0] pulse_cnt_q;
    logic             rx_take;
    logic [3:0]       dec_code;
    logic             dec_accept;

    // A byte is taken only in IDLE with no byte already captured.
    assign rx_take = rx_done && (state_q == ST_IDLE) && !pend_q;

`ifdef UART_CMD_HAMMING_EN
    logic       dec_fix;
    logic [7:0] err_count_q;

    hamming_7_4_decoder u_hamming (
        .hamming_in     (rx_byte_q[6:0]),
        .data_out       (dec_code),
        .error_detected (dec_fix)
    );

    // Accept requires clean parity, bit 7 clear and a known command.
    always_comb begin
        dec_accept = !perr_q && !rx_byte_q[7] && cmd_mapped(dec_code);
    end

    // Saturating count of corrected single-bit errors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count_q <= 8'h00;
        end else if ((state_q == ST_DECODE) && dec_fix && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
        end
    end

    assign err_count = err_count_q;
`else
    assign dec_code = rx_byte_q[3:0];

    // Accept requires clean parity, an all-zero upper nibble and a known command.
    always_comb begin
        dec_accept = !perr_q && (rx_byte_q[7:4] == 4'h0) && cmd_mapped(dec_code);
    end

    assign err_count = 8'h00;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (pend_q) state_d = ST_DECODE;
            ST_DECODE:    state_d = ST_EXEC;
            ST_EXEC:      state_d = ST_SEND_REQ;
            ST_SEND_REQ:  if (tx_busy) state_d = ST_SEND_WAIT;
            ST_SEND_WAIT: if (!tx_busy) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Byte capture and sticky overrun for any strobe that cannot be taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q    <= 1'b0;
            rx_byte_q <= 8'h00;
            perr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pend_q <= rx_take;
            if (rx_take) begin
                rx_byte_q <= data_received;
                perr_q    <= parity_error;
            end
            if (rx_done && !rx_take) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Decoded command registered at the end of DECODE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code_q   <= 4'h0;
            accept_q <= 1'b0;
        end else if (state_q == ST_DECODE) begin
            code_q   <= dec_code;
            accept_q <= dec_accept;
        end
    end

    // EXEC applies the command and loads the reply, which then holds until the next EXEC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_q     <= 1'b0;
            data_to_tx_q <= 8'h00;
        end else if (state_q == ST_EXEC) begin
            data_to_tx_q <= accept_q ? ACK_BYTE : NACK_BYTE;
            if (accept_q) begin
                case (code_q)
                    CMD_ON:     enable_q <= 1'b1;
                    CMD_OFF:    enable_q <= 1'b0;
                    CMD_TOGGLE: enable_q <= ~enable_q;
                    default:    enable_q <= enable_q;
                endcase
            end
        end
    end

    // Shoot pulse down-counter; an accepted SHOOT reloads it even mid-pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pulse_cnt_q <= '0;
        end else if ((state_q == ST_EXEC) && accept_q && (code_q == CMD_SHOOT)) begin
            pulse_cnt_q <= PULSE_LOAD;
        end else if (pulse_cnt_q != '0) begin
            pulse_cnt_q <= pulse_cnt_q - CNT_W'(1);
        end
    end

    assign data_to_tx = data_to_tx_q;
    assign start_tx   = (state_q == ST_SEND_REQ);
    assign enable     = enable_q;
    assign shoot      = (pulse_cnt_q != '0);
    assign busy       = (state_q != ST_IDLE);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_cmd_handler.sv
// Directed bench for uart_cmd_handler with an expected-reply scoreboard.
// Builds for either decoder flavour depending on UART_CMD_HAMMING_EN.
module tb_uart_cmd_handler;

`ifdef UART_CMD_HAMMING_EN
    localparam logic [7:0] B_ON     = 8'h07;
    localparam logic [7:0] B_ON_ERR = 8'h17;
    localparam logic [7:0] B_OFF    = 8'h19;
    localparam logic [7:0] B_TOG    = 8'h1E;
    localparam logic [7:0] B_SHOOT  = 8'h2A;
    localparam logic [7:0] B_REJ    = 8'h87;
    localparam logic [7:0] ERR_EXP  = 8'h01;
`else
    localparam logic [7:0] B_ON     = 8'h01;
    localparam logic [7:0] B_OFF    = 8'h02;
    localparam logic [7:0] B_TOG    = 8'h03;
    localparam logic [7:0] B_SHOOT  = 8'h04;
    localparam logic [7:0] B_REJ    = 8'h11;
    localparam logic [7:0] ERR_EXP  = 8'h00;
`endif
    localparam logic [7:0] ACK  = 8'h3C;
    localparam logic [7:0] NACK = 8'hC3;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_received;
    logic       rx_done;
    logic       parity_error;
    logic       tx_busy;
    logic [7:0] data_to_tx;
    logic       start_tx;
    logic       enable;
    logic       shoot;
    logic       busy;
    logic [7:0] err_count;
    logic       overrun;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] sb[$];
    logic       exp_enable  = 1'b0;
    logic       exp_overrun = 1'b0;

    int   cyc      = 0;
    int   rise_cyc = -1;
    int   fall_cyc = -1;
    logic shoot_prev = 1'b0;

    uart_cmd_handler dut (
        .clk           (clk),
        .reset         (reset),
        .data_received (data_received),
        .rx_done       (rx_done),
        .parity_error  (parity_error),
        .tx_busy       (tx_busy),
        .data_to_tx    (data_to_tx),
        .start_tx      (start_tx),
        .enable        (enable),
        .shoot         (shoot),
        .busy          (busy),
        .err_count     (err_count),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the clock edge index at which shoot rises and falls.
    always @(negedge clk) begin
        if (shoot === 1'b1 && shoot_prev === 1'b0) rise_cyc = cyc;
        if (shoot === 1'b0 && shoot_prev === 1'b1) fall_cyc = cyc;
        shoot_prev = (shoot === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_data_to_tx"}, data_to_tx, 8'h00);
        chk({tag, "_start_tx"}, start_tx, 1'b0);
        chk({tag, "_enable"}, enable, 1'b0);
        chk({tag, "_shoot"}, shoot, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_err_count"}, err_count, 8'h00);
        chk({tag, "_overrun"}, overrun, 1'b0);
    endtask

    // Busy must stay low for a few cycles (no hidden transaction in flight).
    task automatic chk_quiet(input string tag);
        logic seen;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0) seen = 1'b1;
        end
        chk(tag, seen, 1'b0);
    endtask

    // One command: strobe at edge N, check latency at N+2/N+3, then serve
    // the tx handshake with tx_busy high for busy_len cycles (0 = leave in SEND_REQ).
    task automatic send_cmd(input logic [7:0] b, input logic pe, input logic [7:0] resp,
                            input logic en, input int busy_len, input logic inject);
        logic [7:0] exp_b;
        sb.push_back(resp);
        @(negedge clk);
        data_received = b;
        parity_error  = pe;
        rx_done       = 1'b1;
        @(posedge clk);
        #1;
        rx_done      = 1'b0;
        parity_error = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("enable_pre", enable, exp_enable);
        chk("start_pre", start_tx, 1'b0);
        chk("busy_mid", busy, 1'b1);
        @(posedge clk);
        #1;
        exp_enable = en;
        chk("enable_lat", enable, exp_enable);
        chk("start_lat", start_tx, 1'b1);
        exp_b = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        chk("reply_byte", data_to_tx, exp_b);
        if (busy_len > 0) begin
            @(posedge clk);
            #1;
            chk("start_hold", start_tx, 1'b1);
            @(negedge clk);
            tx_busy = 1'b1;
            @(posedge clk);
            #1;
            chk("start_drop", start_tx, 1'b0);
            chk("busy_wait", busy, 1'b1);
            for (int i = 1; i < busy_len; i++) begin
                @(negedge clk);
                if (inject && i == 2) begin
                    data_received = B_TOG;
                    rx_done       = 1'b1;
                end else begin
                    rx_done = 1'b0;
                end
            end
            @(negedge clk);
            chk("tx_stable", data_to_tx, exp_b);
            rx_done = 1'b0;
            tx_busy = 1'b0;
            @(posedge clk);
            #1;
            chk("back_idle", busy, 1'b0);
            if (inject) exp_overrun = 1'b1;
            chk("overrun", overrun, exp_overrun);
        end
    endtask

    initial begin
        int r;
        reset         = 1'b0;
        data_received = 8'h00;
        rx_done       = 1'b0;
        parity_error  = 1'b0;
        tx_busy       = 1'b0;

        // A byte offered while in reset must be ignored.
        repeat (3) @(posedge clk);
        @(negedge clk);
        data_received = B_ON;
        rx_done       = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        #1;
        chk_reset("rst");
        @(negedge clk);
        reset = 1'b1;
        chk_quiet("post_rst_quiet");
        chk("post_rst_enable", enable, 1'b0);

        send_cmd(B_ON, 1'b0, ACK, 1'b1, 10, 1'b0);
`ifdef UART_CMD_HAMMING_EN
        send_cmd(B_ON_ERR, 1'b0, ACK, 1'b1, 3, 1'b0);
`endif
        chk("err_count", err_count, ERR_EXP);
        send_cmd(B_OFF, 1'b0, ACK, 1'b0, 10, 1'b0);
        send_cmd(B_REJ, 1'b0, NACK, 1'b0, 4, 1'b0);
        send_cmd(B_TOG, 1'b0, ACK, 1'b1, 2, 1'b0);
        send_cmd(B_OFF, 1'b1, NACK, 1'b1, 3, 1'b0);
        send_cmd(8'h00, 1'b0, NACK, 1'b1, 2, 1'b0);
        send_cmd(B_TOG, 1'b0, ACK, 1'b0, 2, 1'b0);

        // Single shoot pulse.
        send_cmd(B_SHOOT, 1'b0, ACK, 1'b0, 1, 1'b0);
        r = rise_cyc;
        for (int i = 0; i < 200 && !(fall_cyc > r); i++) @(negedge clk);
        chk("shoot_fell", (fall_cyc > r), 1'b1);
        chk("shoot_width", fall_cyc - r, 48);

        // Retrigger 20 cycles into a pulse.
        send_cmd(B_SHOOT, 1'b0, ACK, 1'b0, 1, 1'b0);
        r = rise_cyc;
        while (cyc < r + 15) @(negedge clk);
        send_cmd(B_SHOOT, 1'b0, ACK, 1'b0, 1, 1'b0);
        chk("shoot_still_high", shoot, 1'b1);
        for (int i = 0; i < 200 && !(fall_cyc > r); i++) @(negedge clk);
        chk("retrig_no_new_rise", rise_cyc, r);
        chk("retrig_width", fall_cyc - r, 68);

        // Strobe during SEND_WAIT is dropped and flagged.
        send_cmd(B_ON, 1'b0, ACK, 1'b1, 5, 1'b1);
        chk_quiet("ovr_ignored");
        chk("ovr_enable", enable, 1'b1);
        chk("err_count_hold", err_count, ERR_EXP);

        // Reset in SEND_REQ aborts immediately.
        send_cmd(B_OFF, 1'b0, ACK, 1'b0, 0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        exp_enable  = 1'b0;
        exp_overrun = 1'b0;
        chk_reset("midrst");
        @(negedge clk);
        reset = 1'b1;
        chk_quiet("midrst_quiet");

        send_cmd(B_ON, 1'b0, ACK, 1'b1, 3, 1'b0);
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
